// File: rtl/dither_pkg.sv
// Shared types, Bayer matrix and saturation helper for the ordered ditherer.
// Frame-size defaults match the camera's 320x240 active window.
package dither_pkg;

  typedef logic [7:0] pixel_t;

  localparam int DEFAULT_FRAME_WIDTH  = 320;
  localparam int DEFAULT_FRAME_HEIGHT = 240;

  // Standard 4x4 ordered-dither matrix, indexed [row][column].
  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

  function automatic pixel_t sat8(input logic signed [9:0] value);
    if (value < 10'sd0) begin
      sat8 = 8'd0;
    end else if (value > 10'sd255) begin
      sat8 = 8'hFF;
    end else begin
      sat8 = value[7:0];
    end
  endfunction

endpackage

// File: rtl/bayer_offset.sv
// Combinational Bayer threshold offset: (BAYER4[y][x] - 8) <<< BAYER_SHIFT.
// BAYER_SHIFT is limited to 0..3 so the result always fits in signed 10 bits.
module bayer_offset
  import dither_pkg::*;
#(
  parameter int BAYER_SHIFT = 2
) (
  input  logic [1:0]        x,
  input  logic [1:0]        y,
  output logic signed [9:0] offset
);

  logic signed [9:0] centered;

  assign centered = $signed({6'd0, BAYER4[y][x]}) - 10'sd8;
  assign offset   = centered <<< BAYER_SHIFT;

endmodule

// File: rtl/ordered_ditherer.sv
// Raster-tracking 4x4 ordered ditherer, 8-bit gray in, 1-bit out, fixed 2-cycle latency.
// Define ERROR_DIFFUSION_EN to add 1D horizontal error diffusion ahead of the compare.
module ordered_ditherer
  import dither_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int BAYER_SHIFT  = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] gray_pixel_in,
  input  logic       gray_valid_in,
  input  logic       frame_start_in,
  input  logic [7:0] threshold_in,
  output logic       dithered_pixel,
  output logic       dithered_valid,
  output logic       frame_done_out
);

  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  logic [XW-1:0]     x_q, px;
  logic [YW-1:0]     y_q, py;
  pixel_t            thr_q, thr_use, eff, adj;
  logic              start, last;
  logic signed [9:0] offset;

  logic              s1_valid, s1_last;
  pixel_t            s1_adj, s1_eff;
  logic              cmp;

  // A qualified frame start resyncs this very pixel to (0,0) with the fresh threshold.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    start   = gray_valid_in & frame_start_in;
    px      = x_q;
    py      = y_q;
    thr_use = thr_q;
    if (start) begin
      px      = '0;
      py      = '0;
      thr_use = threshold_in;
    end
    last = (px == X_LAST) && (py == Y_LAST);
  end

  bayer_offset #(
    .BAYER_SHIFT(BAYER_SHIFT)
  ) u_bayer_offset (
    .x      (px[1:0]),
    .y      (py[1:0]),
    .offset (offset)
  );

  assign eff = sat8($signed({2'b00, thr_use}) + offset);

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_q   <= '0;
      y_q   <= '0;
      thr_q <= 8'd128;
    end else if (gray_valid_in) begin
      if (px == X_LAST) begin
        x_q <= '0;
        y_q <= (py == Y_LAST) ? '0 : py + 1'b1;
      end else begin
        x_q <= px + 1'b1;
        y_q <= py;
      end
      // Threshold only moves at frame boundaries so a sweep never tears a frame.
      if (start || last) begin
        thr_q <= threshold_in;
      end
    end
  end

  assign cmp = (s1_adj >= s1_eff);

`ifdef ERROR_DIFFUSION_EN
  logic signed [8:0] err_q, err_fwd, err_use;
  logic signed [9:0] err_half;

  // Forward the error of the pixel currently in stage 2 so back-to-back pixels see it.
  always_comb begin
    err_fwd = err_q;
    if (s1_valid) begin
      err_fwd = $signed({1'b0, s1_adj}) - (cmp ? 9'sd255 : 9'sd0);
    end
    err_use  = (px == '0) ? '0 : err_fwd;
    err_half = {err_use[8], err_use[8], err_use[8:1]};
  end

  assign adj = sat8($signed({2'b00, gray_pixel_in}) + err_half);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      err_q <= '0;
    end else begin
      err_q <= err_fwd;
    end
  end
`else
  assign adj = gray_pixel_in;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid       <= 1'b0;
      s1_last        <= 1'b0;
      dithered_valid <= 1'b0;
      dithered_pixel <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      s1_valid       <= gray_valid_in;
      s1_last        <= gray_valid_in & last;
      dithered_valid <= s1_valid;
      dithered_pixel <= s1_valid & cmp;
      frame_done_out <= s1_valid & s1_last;
    end
  end

  // NOTE: stage-1 data is only consumed when s1_valid is set, so these flops carry no reset.
  always_ff @(posedge clk_in) begin
    if (gray_valid_in) begin
      s1_adj <= adj;
      s1_eff <= eff;
    end
  end

endmodule
